// File: rtl/ti_share_split.sv
// ti_share_split: input-side sharing stage for a 3-share TI 4-bit S-box.
// Splits each accepted nibble into Boolean shares s1, s2, s3 using masks taken
// from a 16-bit Fibonacci LFSR. The shares are registered and presented as
// three non-complete share-pair buses. After every accept or reseed the LFSR
// refreshes for REFRESH_STEPS cycles before the next nibble can be taken.
// Optional build macro TI_MASK_OFF_EN forces both masks to zero. It is for
// debug only: the shares then expose the plain nibble.
module ti_share_split #(
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int unsigned REFRESH_STEPS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_data,
   input  logic        reseed,
   input  logic [15:0] seed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_f1,
   output logic [7:0]  out_f2,
   output logic [7:0]  out_f3,
   output logic        busy
);

   typedef enum logic {RDY, REFRESH} state_t;

   localparam logic [3:0] LAST = 4'(REFRESH_STEPS - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [15:0] lfsr, lfsr_nxt;
   logic        fb;
   logic [3:0]  m1, m2;
   logic [3:0]  s1, s2, s3;
   logic        ovalid;
   logic        accept;

   // Mask selection from the current LFSR value, plus the LFSR feedback bit
   always_comb begin
      fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
`ifdef TI_MASK_OFF_EN
      m1 = '0;
      m2 = '0;
`else
      m1 = lfsr[3:0];
      m2 = lfsr[7:4];
`endif
   end

   // Input handshake: only in RDY, never during reset or reseed, and only
   // when the output register is empty or is being drained this cycle
   always_comb begin
      in_ready = (state == RDY) & ~rst & ~reseed & (~ovalid | out_ready);
      accept   = in_valid & in_ready;
   end

   // Next-state logic. Reseed overrides the normal FSM flow.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lfsr_nxt  = lfsr;
      if (reseed) begin
         lfsr_nxt  = (seed == '0) ? SEED : seed;
         state_nxt = REFRESH;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            RDY: begin
               if (accept) begin
                  state_nxt = REFRESH;
                  cnt_nxt   = '0;
               end
            end
            REFRESH: begin
               lfsr_nxt = {lfsr[14:0], fb};
               cnt_nxt  = cnt + 4'd1;
               if (cnt == LAST) begin
                  state_nxt = RDY;
                  cnt_nxt   = '0;
               end
            end
            default: begin
               state_nxt = RDY;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State, refresh counter and LFSR registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RDY;
         cnt   <= '0;
         lfsr  <= SEED;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         lfsr  <= lfsr_nxt;
      end
   end

   // Share output register. An accept in the same cycle as a drain replaces
   // the sharing, so out_valid stays high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovalid <= 1'b0;
         s1     <= '0;
         s2     <= '0;
         s3     <= '0;
      end else if (accept) begin
         ovalid <= 1'b1;
         s1     <= m1;
         s2     <= m2;
         s3     <= in_data ^ m1 ^ m2;
      end else if (ovalid && out_ready) begin
         ovalid <= 1'b0;
      end
   end

   // Non-complete share-pair buses and status outputs
   always_comb begin
      out_valid = ovalid;
      out_f1    = {s2, s3};
      out_f2    = {s1, s3};
      out_f3    = {s1, s2};
      busy      = (state == REFRESH);
   end

endmodule
